// File: rtl/wb_line_memory.sv
// wb_line_memory: line-granular memory responder on a stb/cyc/we/ack bus.
// Acks after a programmable latency; cyc_in low while waiting aborts the request.
module wb_line_memory #(
   parameter int LATENCY  = 4,
   parameter int ADDR_W   = 16,
   parameter int LINE_W   = 128,
   parameter int OFFSET_W = 4,
   parameter int IDX_W    = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cyc_in,
   input  logic              stb_in,
   input  logic              we_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [LINE_W-1:0] wdata_in,
   output logic              ack_out,
   output logic [LINE_W-1:0] rdata_out,
   output logic              busy_out
);
   typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} state_t;
   state_t state, state_nx;
   logic [7:0] cnt;
   logic we_q, we_cur, enter_ack, addr_unused;
   logic [IDX_W-1:0] idx_q, idx_cur;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] mem [2**IDX_W];
   assign addr_unused = ^addr_in;
   // With LATENCY=1 the line is committed on the accepting edge, so use live inputs.
   assign idx_cur = (state == IDLE) ? addr_in[OFFSET_W+IDX_W-1:OFFSET_W] : idx_q;
   assign we_cur = (state == IDLE) ? we_in : we_q;
   assign enter_ack = state_nx == ACK;
   assign ack_out = state == ACK;
   assign busy_out = state != IDLE;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (cyc_in && stb_in) state_nx = (LATENCY > 1) ? WAIT : ACK;
         WAIT: state_nx = !cyc_in ? IDLE : (cnt <= 8'd1) ? ACK : WAIT;
         ACK: state_nx = GAP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         we_q <= 1'b0;
         idx_q <= '0;
         wdata_q <= '0;
         rdata_out <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && cyc_in && stb_in) begin
            we_q <= we_in;
            idx_q <= addr_in[OFFSET_W+IDX_W-1:OFFSET_W];
            wdata_q <= wdata_in;
            cnt <= 8'(LATENCY - 1);
         end else if (state == WAIT) begin
            cnt <= cnt - 8'd1;
         end
         if (enter_ack && !we_cur) rdata_out <= mem[idx_cur];
      end
   end
   always_ff @(posedge clk) begin
      if (rst_n && enter_ack && we_cur) mem[idx_cur] <= (state == IDLE) ? wdata_in : wdata_q;
   end
endmodule

// File: tb/tb_wb_line_memory.sv
// tb_wb_line_memory: checks latency, abort, reset, aliasing and random traffic
// against an array model of line memory, on LATENCY=4 and LATENCY=1 instances.
module tb_wb_line_memory;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cyc4 = 0, stb4 = 0, we4 = 0, ack4, busy4;
   logic cyc1 = 0, stb1 = 0, we1 = 0, ack1, busy1;
   logic [15:0] addr4 = '0, addr1 = '0;
   logic [127:0] wd4 = '0, wd1 = '0, rd4, rd1;
   int n_cmp = 0, n_bad = 0;
   logic [127:0] mem_m [64];
   logic [127:0] mem1_m [64];
   logic [127:0] rd_m = '0, ack_rd;
   int lat, n_ack;

   always #5 clk = ~clk;

   wb_line_memory #(.LATENCY(4)) dut (.clk(clk), .rst_n(rst_n), .cyc_in(cyc4), .stb_in(stb4),
      .we_in(we4), .addr_in(addr4), .wdata_in(wd4), .ack_out(ack4), .rdata_out(rd4), .busy_out(busy4));
   wb_line_memory #(.LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .cyc_in(cyc1), .stb_in(stb1),
      .we_in(we1), .addr_in(addr1), .wdata_in(wd1), .ack_out(ack1), .rdata_out(rd1), .busy_out(busy1));

   function automatic int idx(input logic [15:0] a);
      return (int'(a) / 16) % 64;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic drive(input bit u, input bit c, input bit w, input logic [15:0] a, input logic [127:0] d);
      if (u) begin cyc1 = c; stb1 = c; we1 = w; addr1 = a; wd1 = d; end
      else begin cyc4 = c; stb4 = c; we4 = w; addr4 = a; wd4 = d; end
   endtask

   // One full transaction, strobe held through ack and gap; records ack cycle and data.
   task automatic xact(input bit u, input bit w, input logic [15:0] a, input logic [127:0] d);
      @(negedge clk);
      drive(u, 1, w, a, d);
      lat = -1;
      n_ack = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (u ? ack1 : ack4) begin
            n_ack++;
            if (lat < 0) begin lat = i; ack_rd = u ? rd1 : rd4; end
         end
         if (lat >= 0 && i == lat + 1) break;
      end
      @(negedge clk);
      drive(u, 0, 0, a, d);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (ack4 !== 1'b0 || busy4 !== 1'b0) begin n_bad++; $display("FAIL reset4_ctl got ack=%b busy=%b want 0 0", ack4, busy4); end
      n_cmp++; if (rd4 !== '0) begin n_bad++; $display("FAIL reset4_rdata got %h want 0", rd4); end
      n_cmp++; if (ack1 !== 1'b0 || busy1 !== 1'b0 || rd1 !== '0) begin n_bad++; $display("FAIL reset1 got ack=%b busy=%b rd=%h want 0", ack1, busy1, rd1); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy got %b want 0", busy4); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 64; i++) begin
         mem_m[i] = rnd128();
         xact(0, 1, 16'(i * 16), mem_m[i]);
         n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL fill_lat idx=%0d got %0d want 4", i, lat); end
      end
   endtask

   task automatic test_read_latency();
      logic [7:0] ack_bits, busy_bits;
      mem_m[2] = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
      xact(0, 1, 16'h0020, mem_m[2]);
      ack_bits = '0;
      busy_bits = '0;
      @(negedge clk);
      drive(0, 1, 0, 16'h0020, '0);
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         ack_bits[i] = ack4;
         busy_bits[i] = busy4;
         if (i == 4) ack_rd = rd4;
         if (i == 5) begin @(negedge clk); drive(0, 0, 0, 16'h0020, '0); end
      end
      rd_m = mem_m[2];
      n_cmp++; if (ack_bits !== 8'h10) begin n_bad++; $display("FAIL rl_ack_cycles got %b want 00010000", ack_bits); end
      n_cmp++; if (busy_bits !== 8'h3E) begin n_bad++; $display("FAIL rl_busy_cycles got %b want 00111110", busy_bits); end
      n_cmp++; if (ack_rd !== rd_m) begin n_bad++; $display("FAIL rl_data got %h want %h", ack_rd, rd_m); end
   endtask

   task automatic test_write_read();
      logic [127:0] v = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
      xact(0, 1, 16'h0130, v);
      mem_m[idx(16'h0130)] = v;
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL wr_lat got %0d want 4", lat); end
      n_cmp++; if (ack_rd !== rd_m) begin n_bad++; $display("FAIL wr_rdata_held got %h want %h", ack_rd, rd_m); end
      xact(0, 0, 16'h013C, rnd128());
      rd_m = mem_m[idx(16'h013C)];
      n_cmp++; if (lat !== 4 || ack_rd !== rd_m) begin n_bad++; $display("FAIL rd_after_wr got lat=%0d %h want 4 %h", lat, ack_rd, rd_m); end
   endtask

   task automatic test_abort();
      logic [2:0] busy_bits = '0;
      n_ack = 0;
      @(negedge clk);
      drive(0, 1, 1, 16'h0050, ~mem_m[5]);
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (ack4) n_ack++;
         if (i <= 3) busy_bits[i-1] = busy4;
         if (i == 2) drive(0, 0, 1, 16'h0050, ~mem_m[5]);
      end
      n_cmp++; if (n_ack !== 0) begin n_bad++; $display("FAIL abort_ack got %0d acks want 0", n_ack); end
      n_cmp++; if (busy_bits !== 3'b011) begin n_bad++; $display("FAIL abort_busy got %b want 011", busy_bits); end
      xact(0, 0, 16'h0058, '0);
      rd_m = mem_m[5];
      n_cmp++; if (ack_rd !== rd_m) begin n_bad++; $display("FAIL abort_data got %h want %h", ack_rd, rd_m); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ack_bits = '0;
      logic [127:0] r1 = '0, r2 = '0;
      @(negedge clk);
      drive(0, 1, 0, 16'h0070, '0);
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk); #1;
         ack_bits[i] = ack4;
         if (i == 4) r1 = rd4;
         if (i == 10) r2 = rd4;
         if (i == 2) addr4 = 16'h03F0;
         if (i == 5) addr4 = 16'h0090;
         if (i == 11) drive(0, 0, 0, 16'h0090, '0);
      end
      rd_m = mem_m[9];
      n_cmp++; if (ack_bits !== 16'h0410) begin n_bad++; $display("FAIL b2b_ack_cycles got %b want 0000010000010000", ack_bits); end
      n_cmp++; if (r1 !== mem_m[7]) begin n_bad++; $display("FAIL b2b_first got %h want %h", r1, mem_m[7]); end
      n_cmp++; if (r2 !== mem_m[9]) begin n_bad++; $display("FAIL b2b_second got %h want %h", r2, mem_m[9]); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive(0, 1, 1, 16'h00B0, ~mem_m[11]);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_cmp++; if (ack4 !== 1'b0 || busy4 !== 1'b0) begin n_bad++; $display("FAIL rst_wait got ack=%b busy=%b want 0 0", ack4, busy4); end
      @(negedge clk) drive(0, 0, 0, 16'h00B0, '0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      drive(0, 1, 0, 16'h0020, '0);
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (ack4 !== 1'b1) begin n_bad++; $display("FAIL rst_pre_ack got %b want 1", ack4); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (ack4 !== 1'b0 || busy4 !== 1'b0 || rd4 !== '0) begin n_bad++; $display("FAIL rst_ack got ack=%b busy=%b rd=%h want 0 0 0", ack4, busy4, rd4); end
      @(negedge clk) drive(0, 0, 0, 16'h0020, '0);
      @(negedge clk) rst_n = 1'b1;
      xact(0, 0, 16'h00B4, '0);
      rd_m = mem_m[11];
      n_cmp++; if (ack_rd !== rd_m) begin n_bad++; $display("FAIL rst_old_data got %h want %h", ack_rd, rd_m); end
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [127:0] d;
      bit w;
      for (int k = 0; k < 40; k++) begin
         w = 1'($urandom_range(0, 1));
         a = 16'($urandom_range(0, 65535));
         d = rnd128();
         repeat ($urandom_range(0, 2)) @(posedge clk);
         xact(0, w, a, d);
         if (w) mem_m[idx(a)] = d;
         else rd_m = mem_m[idx(a)];
         n_cmp++; if (lat !== 4 || n_ack !== 1) begin n_bad++; $display("FAIL rnd_lat k=%0d got lat=%0d acks=%0d want 4 1", k, lat, n_ack); end
         n_cmp++; if (ack_rd !== rd_m) begin n_bad++; $display("FAIL rnd_data k=%0d we=%0b got %h want %h", k, w, ack_rd, rd_m); end
      end
   endtask

   task automatic test_lat1();
      logic [127:0] p = rnd128(), q = rnd128();
      xact(1, 1, 16'h0000, p);
      mem1_m[idx(16'h0000)] = p;
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL l1_wr_lat got %0d want 1", lat); end
      xact(1, 0, 16'h0400, '0);
      n_cmp++; if (lat !== 1 || ack_rd !== mem1_m[idx(16'h0400)]) begin n_bad++; $display("FAIL l1_alias0 got lat=%0d %h want 1 %h", lat, ack_rd, mem1_m[0]); end
      xact(1, 1, 16'h0410, q);
      mem1_m[idx(16'h0410)] = q;
      xact(1, 0, 16'h8018, '0);
      n_cmp++; if (lat !== 1 || ack_rd !== mem1_m[idx(16'h8018)]) begin n_bad++; $display("FAIL l1_alias1 got lat=%0d %h want 1 %h", lat, ack_rd, mem1_m[1]); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_read_latency();
      test_write_read();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_lat1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
